// File: rtl/mp_reg.sv
// Multi-channel masked register: local always-on masked write plus CHANNELS
// valid/ready requesters with one-entry buffers and a round-robin commit arbiter.
// Optional per-channel post-commit readback is enabled by MP_REG_READBACK_EN.
module mp_reg #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      CHANNELS    = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '1
) (
  input  logic                      fclk,
  input  logic                      frst,
  input  logic [WIDTH-1:0]          value_mask,
  input  logic [WIDTH-1:0]          value_in,
  output logic [WIDTH-1:0]          value_out,
  input  logic [CHANNELS-1:0]       ch_valid,
  output logic [CHANNELS-1:0]       ch_ready,
  input  logic [CHANNELS*WIDTH-1:0] ch_mask,
  input  logic [CHANNELS*WIDTH-1:0] ch_value,
  output logic [CHANNELS-1:0]       ch_done
`ifdef MP_REG_READBACK_EN
  ,
  output logic [CHANNELS*WIDTH-1:0] ch_rdata
`endif
);

  localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    value_q, value_d;
  logic [CHANNELS-1:0] full_q, full_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [WIDTH-1:0]    bmask_q [CHANNELS];
  logic [WIDTH-1:0]    bmask_d [CHANNELS];
  logic [WIDTH-1:0]    bval_q  [CHANNELS];
  logic [WIDTH-1:0]    bval_d  [CHANNELS];
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                gnt_vld;
  logic [PW-1:0]       gnt_idx;
  logic [WIDTH-1:0]    v1, v2;

  // Cyclic search for the first full buffer strictly after the last grant.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx  = (32'(ptr_q) + k) % CHANNELS;
      cand = PW'(idx);
      if (!gnt_vld && full_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    v1 = (value_in & value_mask) | (value_q & ~value_mask);
    v2 = v1;
    if (gnt_vld) begin
      v2 = (bval_q[gnt_idx] & bmask_q[gnt_idx]) | (v1 & ~bmask_q[gnt_idx]);
    end
    value_d = v2;
    full_d  = full_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    bmask_d = bmask_q;
    bval_d  = bval_q;
    if (gnt_vld) begin
      full_d[gnt_idx] = 1'b0;
      done_d[gnt_idx] = 1'b1;
      ptr_d           = gnt_idx;
    end
    // A granted buffer is full, an accepting one is empty, so they never collide.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch_valid[i] && !full_q[i] && (ch_mask[i*WIDTH +: WIDTH] != '0)) begin
        full_d[i]  = 1'b1;
        bmask_d[i] = ch_mask[i*WIDTH +: WIDTH];
        bval_d[i]  = ch_value[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge fclk) begin
    bmask_q <= bmask_d;
    bval_q  <= bval_d;
    if (frst) begin
      value_q <= (RESET_VALUE & RESET_MASK) | (value_q & ~RESET_MASK);
      full_q  <= '0;
      done_q  <= '0;
      ptr_q   <= PW'(CHANNELS - 1);
    end else begin
      value_q <= value_d;
      full_q  <= full_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
    end
  end

  assign value_out = value_q;
  assign ch_ready  = ~full_q;
  assign ch_done   = done_q;

`ifdef MP_REG_READBACK_EN
  logic [CHANNELS*WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (gnt_vld) begin
      rdata_d[gnt_idx*WIDTH +: WIDTH] = v2;
    end
  end

  always_ff @(posedge fclk) begin
    if (frst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign ch_rdata = rdata_q;
`endif

endmodule
